// File: rtl/cpu_pkg.sv
// Shared CPU-top definitions: data-memory arbiter state encoding and default bus widths.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOST = 2'd3
  } arb_state_t;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/dmem_port_arbiter_port_mux.sv
// Combinational host/core selection of the data-memory port; zero latency, no backpressure.
// host_vld qualifies host writes so an idle or reset host never writes memory.
module port_mux
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              host_sel,
  input  logic              host_vld,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  always_comb begin
    if (host_sel) begin
      mem_we    = host_vld & host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port owner: holds the core in reset during host load, then steals stall slots for host accesses.
// Host grant is same-cycle in LOAD/HOLD, at most HOST_WAIT+1 RUN cycles late otherwise; read data returns one cycle after grant.
module dmem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int HOST_WAIT  = 4,
  parameter int RESET_HOLD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_reload,
  input  logic              load_done,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              cpu_mem_access,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rst,
  output logic              cpu_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam int WW = $clog2(HOST_WAIT + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(HOST_WAIT);

  arb_state_t        state_q, state_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              reload_pend_q, reload_pend_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              cpu_stall_q, cpu_stall_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_sel;

  assign host_sel = (state_q != ST_RUN);
  assign host_gnt = reset & ((state_q == ST_HOST) | (host_sel & host_req));

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    reload_pend_d = reload_pend_q;
    host_rvalid_d = host_gnt & ~host_we;
    host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;

    case (state_q)
      ST_LOAD: begin
        wait_cnt_d    = '0;
        reload_pend_d = 1'b0;
        if (load_done) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q - HW'(1);
        if (hold_cnt_q <= HW'(1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A reload (fresh or parked during a host slot) beats any pending host slot.
        if (host_reload | reload_pend_q) begin
          state_d       = ST_LOAD;
          reload_pend_d = 1'b0;
          wait_cnt_d    = '0;
        end else if (!host_req) begin
          wait_cnt_d = '0;
        end else if (!cpu_mem_access) begin
          state_d = ST_HOST;
        end else if (wait_cnt_q == WAIT_MAX) begin
          state_d = ST_HOST;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      ST_HOST: begin
        wait_cnt_d = '0;
        state_d    = ST_RUN;
        if (host_reload) reload_pend_d = 1'b1;
      end
      default: state_d = ST_LOAD;
    endcase

    cpu_rst_d   = (state_d == ST_LOAD) || (state_d == ST_HOLD);
    cpu_stall_d = (state_d == ST_HOST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_LOAD;
      hold_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      reload_pend_q <= 1'b0;
      cpu_rst_q     <= 1'b1;
      cpu_stall_q   <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      reload_pend_q <= reload_pend_d;
      cpu_rst_q     <= cpu_rst_d;
      cpu_stall_q   <= cpu_stall_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign cpu_rst     = cpu_rst_q;
  assign cpu_stall   = cpu_stall_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

  port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .host_sel   (host_sel),
    .host_vld   (reset & host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed bring-up/arbitration scenarios plus a randomized run against a phase-level reference model.
module tb_dmem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int HOST_WAIT  = 4;
  localparam int RESET_HOLD = 2;
  localparam int P_LOAD = 0, P_HOLD = 1, P_RUN = 2, P_HOST = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              host_req, host_we, host_reload, load_done;
  logic [ADDR_W-1:0] host_addr, cpu_addr, mem_addr;
  logic [DATA_W-1:0] host_wdata, cpu_wdata, mem_wdata, mem_rdata, host_rdata;
  logic              host_gnt, host_rvalid, cpu_mem_access, cpu_we, cpu_rst, cpu_stall, mem_we;

  // Environment memory (driven only by the DUT's port) and the model's private copy.
  logic [DATA_W-1:0] mem [64];
  bit                mem_vld [64];
  logic [DATA_W-1:0] ref_mem [64];

  int                m_phase, m_release_in, m_waited;
  bit                m_reload_pend, m_rvalid, m_last_gnt;
  logic [DATA_W-1:0] m_rdata;
  int                total = 0;
  int                bad = 0;

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOST_WAIT(HOST_WAIT), .RESET_HOLD(RESET_HOLD)
  ) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_reload(host_reload), .load_done(load_done),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .cpu_mem_access(cpu_mem_access), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rst(cpu_rst), .cpu_stall(cpu_stall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_vld[mem_addr[7:2]] ? mem[mem_addr[7:2]] : {16'hA5A5, 10'd0, mem_addr[7:2]};

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:2]]     <= mem_wdata;
      mem_vld[mem_addr[7:2]] <= 1'b1;
    end
  end

  // ---------------- reference model ----------------
  function automatic bit exp_gnt();
    return reset && (m_phase == P_HOST || (m_phase != P_RUN && host_req));
  endfunction

  function automatic bit exp_mem_we();
    if (m_phase != P_RUN) return reset && host_req && host_we;
    return cpu_we;
  endfunction

  function automatic logic [ADDR_W-1:0] exp_addr();
    return (m_phase != P_RUN) ? host_addr : cpu_addr;
  endfunction

  function automatic logic [DATA_W-1:0] exp_wdata();
    return (m_phase != P_RUN) ? host_wdata : cpu_wdata;
  endfunction

  task automatic model_reset();
    m_phase = P_LOAD; m_release_in = 0; m_waited = 0;
    m_reload_pend = 0; m_rvalid = 0; m_rdata = '0; m_last_gnt = 0;
  endtask

  task automatic model_edge();
    bit                g;
    logic [ADDR_W-1:0] a;
    if (!reset) begin
      model_reset();
      return;
    end
    g = exp_gnt();
    a = exp_addr();
    m_last_gnt = g;
    if (g && !host_we) begin
      m_rvalid = 1;
      m_rdata  = ref_mem[host_addr[7:2]];
    end else begin
      m_rvalid = 0;
    end
    if (exp_mem_we()) ref_mem[a[7:2]] = exp_wdata();
    case (m_phase)
      P_LOAD: if (load_done) begin m_phase = P_HOLD; m_release_in = RESET_HOLD; end
      P_HOLD: begin
        m_release_in--;
        if (m_release_in == 0) m_phase = P_RUN;
      end
      P_RUN: begin
        if (host_reload || m_reload_pend) begin
          m_phase = P_LOAD; m_reload_pend = 0; m_waited = 0;
        end else if (!host_req) begin
          m_waited = 0;
        end else if (!cpu_mem_access) begin
          m_phase = P_HOST; m_waited = 0;
        end else begin
          // m_waited counts contended cycles including this one; the slot is forced on the one past HOST_WAIT.
          m_waited++;
          if (m_waited > HOST_WAIT) begin m_phase = P_HOST; m_waited = 0; end
        end
      end
      default: begin
        if (host_reload) m_reload_pend = 1;
        m_phase = P_RUN;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_reload = 0; load_done = 0;
    cpu_mem_access = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    model_reset();
    host_req = 1; host_we = 1; host_addr = 32'h8; host_wdata = 32'h1111_2222;
    tick();
    #1;
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_cpu_stall got=%b exp=0", cpu_stall); end
    total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", host_rvalid); end
    total++; if (host_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", host_rdata); end
    total++; if (host_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0", host_gnt); end
    tick();
    reset = 1'b1;
    host_req = 0; host_we = 0;
  endtask

  task automatic test_load_write();
    host_req = 1; host_we = 1; host_addr = 32'h10; host_wdata = 32'hDEAD_BEEF;
    #1;
    total++; if (host_gnt !== 1'b1) begin bad++; $display("FAIL load_gnt got=%b exp=1", host_gnt); end
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL load_mem_we got=%b exp=1", mem_we); end
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL load_cpu_rst got=%b exp=1", cpu_rst); end
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL load_mem_addr got=%h exp=10", mem_addr); end
    total++; if (mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_mem_wdata got=%h exp=deadbeef", mem_wdata); end
    tick();
    host_req = 0; host_we = 0;
  endtask

  task automatic test_hold_release();
    load_done = 1; cpu_addr = 32'h44;
    tick();
    load_done = 0;
    #1;
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL hold_edge0 cpu_rst got=%b exp=1", cpu_rst); end
    tick();
    #1;
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL hold_edge1 cpu_rst got=%b exp=1", cpu_rst); end
    tick();
    #1;
    total++; if (cpu_rst !== 1'b0) begin bad++; $display("FAIL hold_edge2 cpu_rst got=%b exp=0", cpu_rst); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL run_stall got=%b exp=0", cpu_stall); end
    total++; if (mem_addr !== 32'h44) begin bad++; $display("FAIL run_mux_addr got=%h exp=44", mem_addr); end
  endtask

  task automatic test_contended_read();
    int   n  = -1;
    logic st = 1'b0;
    cpu_mem_access = 1; cpu_we = 0; cpu_addr = 32'h48;
    host_req = 1; host_we = 0; host_addr = 32'h10;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (host_gnt === 1'b1) begin n = i; st = cpu_stall; break; end
      tick();
    end
    total++; if (n != HOST_WAIT + 1) begin bad++; $display("FAIL contend_latency got=%0d exp=%0d", n, HOST_WAIT + 1); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL contend_stall got=%b exp=1", st); end
    tick();
    host_req = 0;
    #1;
    total++; if (host_rvalid !== 1'b1) begin bad++; $display("FAIL contend_rvalid got=%b exp=1", host_rvalid); end
    total++; if (host_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL contend_rdata got=%h exp=deadbeef", host_rdata); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL contend_after_stall got=%b exp=0", cpu_stall); end
    cpu_mem_access = 0;
  endtask

  task automatic test_free_slot();
    cpu_mem_access = 0; cpu_we = 0;
    host_req = 1; host_we = 0; host_addr = 32'h20;
    #1;
    total++; if (host_gnt !== 1'b0) begin bad++; $display("FAIL free_gnt_early got=%b exp=0", host_gnt); end
    tick();
    cpu_mem_access = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hBAD0_BAD0;
    #1;
    total++; if (host_gnt !== 1'b1) begin bad++; $display("FAIL free_gnt got=%b exp=1", host_gnt); end
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL free_stall got=%b exp=1", cpu_stall); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL free_core_write_blocked got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 32'h20) begin bad++; $display("FAIL free_mem_addr got=%h exp=20", mem_addr); end
    tick();
    host_req = 0; cpu_we = 0; cpu_mem_access = 0;
    #1;
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL free_one_stall got=%b exp=0", cpu_stall); end
    total++; if (host_rvalid !== 1'b1) begin bad++; $display("FAIL free_rvalid got=%b exp=1", host_rvalid); end
    total++; if (host_rdata !== 32'hA5A5_0008) begin bad++; $display("FAIL free_rdata got=%h exp=a5a50008", host_rdata); end
    tick();
    #1;
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL free_stall_gone got=%b exp=0", cpu_stall); end
  endtask

  task automatic test_reload();
    cpu_mem_access = 0;
    host_req = 1; host_we = 1; host_addr = 32'h24; host_wdata = 32'hCAFE_F00D; host_reload = 1;
    #1;
    total++; if (host_gnt !== 1'b0) begin bad++; $display("FAIL reload_gnt_run got=%b exp=0", host_gnt); end
    tick();
    host_reload = 0;
    #1;
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL reload_cpu_rst got=%b exp=1", cpu_rst); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reload_no_slot got=%b exp=0", cpu_stall); end
    total++; if (host_gnt !== 1'b1) begin bad++; $display("FAIL reload_gnt_load got=%b exp=1", host_gnt); end
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL reload_mem_we got=%b exp=1", mem_we); end
    tick();
    host_req = 0; host_we = 0; load_done = 1;
    tick();
    load_done = 0;
    tick();
    tick();
    #1;
    total++; if (cpu_rst !== 1'b0) begin bad++; $display("FAIL reload_rerun cpu_rst got=%b exp=0", cpu_rst); end
  endtask

  task automatic test_async_reset();
    cpu_mem_access = 0;
    host_req = 1; host_we = 0; host_addr = 32'h10;
    tick();
    #1;
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL areset_pre_host got=%b exp=1", cpu_stall); end
    #2 reset = 1'b0;
    model_reset();
    #1;
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL areset_host_cpu_rst got=%b exp=1", cpu_rst); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL areset_host_stall got=%b exp=0", cpu_stall); end
    total++; if (host_gnt !== 1'b0) begin bad++; $display("FAIL areset_host_gnt got=%b exp=0", host_gnt); end
    tick();
    reset = 1'b1;
    load_done = 1;
    #1;
    total++; if (host_gnt !== 1'b1) begin bad++; $display("FAIL areset_relaunch_gnt got=%b exp=1", host_gnt); end
    tick();
    load_done = 0; host_req = 0;
    #1;
    total++; if (host_rvalid !== 1'b1) begin bad++; $display("FAIL areset_hold_rvalid got=%b exp=1", host_rvalid); end
    total++; if (host_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL areset_hold_rdata got=%h exp=deadbeef", host_rdata); end
    #2 reset = 1'b0;
    model_reset();
    #1;
    total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL areset_hold_rvalid_clr got=%b exp=0", host_rvalid); end
    total++; if (host_rdata !== 32'h0) begin bad++; $display("FAIL areset_hold_rdata_clr got=%h exp=0", host_rdata); end
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL areset_hold_cpu_rst got=%b exp=1", cpu_rst); end
    tick();
    reset = 1'b1;
    load_done = 1;
    tick();
    load_done = 0;
    #1;
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL areset_restart_hold got=%b exp=1", cpu_rst); end
    tick();
    tick();
    #1;
    total++; if (cpu_rst !== 1'b0) begin bad++; $display("FAIL areset_restart_run got=%b exp=0", cpu_rst); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2500; c++) begin
      if (!(host_req && !m_last_gnt)) begin
        host_req   = ($urandom_range(0, 2) == 0);
        host_we    = ($urandom_range(0, 1) == 1);
        host_addr  = $urandom_range(0, 63) << 2;
        host_wdata = $urandom;
      end
      cpu_mem_access = ($urandom_range(0, 3) != 0);
      cpu_we         = cpu_mem_access && ($urandom_range(0, 1) == 1);
      cpu_addr       = $urandom_range(0, 63) << 2;
      cpu_wdata      = $urandom;
      load_done      = (m_phase == P_LOAD || m_phase == P_HOLD) && ($urandom_range(0, 5) == 0);
      host_reload    = (m_phase == P_RUN || m_phase == P_HOST) && ($urandom_range(0, 39) == 0);
      #1;
      total++; if (host_gnt !== exp_gnt()) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, host_gnt, exp_gnt()); end
      total++; if (mem_we !== exp_mem_we()) begin bad++; $display("FAIL rnd_mem_we cyc=%0d got=%b exp=%b", c, mem_we, exp_mem_we()); end
      total++; if (mem_addr !== exp_addr()) begin bad++; $display("FAIL rnd_mem_addr cyc=%0d got=%h exp=%h", c, mem_addr, exp_addr()); end
      total++; if (mem_wdata !== exp_wdata()) begin bad++; $display("FAIL rnd_mem_wdata cyc=%0d got=%h exp=%h", c, mem_wdata, exp_wdata()); end
      total++; if (cpu_rst !== (m_phase == P_LOAD || m_phase == P_HOLD)) begin bad++; $display("FAIL rnd_cpu_rst cyc=%0d got=%b phase=%0d", c, cpu_rst, m_phase); end
      total++; if (cpu_stall !== (m_phase == P_HOST)) begin bad++; $display("FAIL rnd_cpu_stall cyc=%0d got=%b phase=%0d", c, cpu_stall, m_phase); end
      total++; if (host_rvalid !== m_rvalid) begin bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, host_rvalid, m_rvalid); end
      total++; if (host_rdata !== m_rdata) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, host_rdata, m_rdata); end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = {16'hA5A5, 10'd0, 6'(i)};
    test_reset();
    test_load_write();
    test_hold_release();
    test_contended_read();
    test_free_slot();
    test_reload();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
